// File: rtl/rd_port_arbiter.sv
// Round-robin arbiter sharing one AXI-style read port between the IFM and WGT fetchers.
// Optional beat-count protocol checker is built when RD_ARB_BEAT_CHECK_EN is defined.
module rd_port_arbiter #(
   parameter int AW    = 32,
   parameter int DW    = 64,
   parameter int BURST = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ifm_arvalid,
   input  logic [AW-1:0] ifm_araddr,
   output logic          ifm_arready,
   output logic          ifm_rvalid,
   output logic          ifm_rlast,
   input  logic          wgt_arvalid,
   input  logic [AW-1:0] wgt_araddr,
   output logic          wgt_arready,
   output logic          wgt_rvalid,
   output logic          wgt_rlast,
   output logic [DW-1:0] rdata,
   output logic          m_arvalid,
   output logic [AW-1:0] m_araddr,
   output logic [7:0]    m_arlen,
   input  logic          m_arready,
   input  logic          m_rvalid,
   input  logic          m_rlast,
   input  logic [DW-1:0] m_rdata,
   output logic          m_rready,
   output logic          grant_id,
   output logic          busy,
   output logic          beat_err,
   output logic [1:0]    fsm_state
);

   // Handshakes: a request transfers when *_arvalid & *_arready (IDLE only);
   // the address transfers on m_arvalid & m_arready; a beat transfers on m_rvalid & m_rready.
   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

   state_t state;
   logic   last_gnt;
   logic   pick_wgt;
   logic   req_any;
   logic   in_idle;
   logic   in_data;

   always_comb begin
      req_any  = ifm_arvalid | wgt_arvalid;
      // WGT wins when alone, or on a tie when IFM was granted last.
      pick_wgt = wgt_arvalid & (~ifm_arvalid | ~last_gnt);
      in_idle  = (state == IDLE);
      in_data  = (state == DATA);
   end

   assign ifm_arready = in_idle & ~rst & ifm_arvalid & ~pick_wgt;
   assign wgt_arready = in_idle & ~rst & pick_wgt;

   assign ifm_rvalid = in_data & ~grant_id & m_rvalid;
   assign wgt_rvalid = in_data &  grant_id & m_rvalid;
   assign ifm_rlast  = ifm_rvalid & m_rlast;
   assign wgt_rlast  = wgt_rvalid & m_rlast;
   assign rdata      = m_rdata;

   assign m_arvalid = (state == ADDR);
   assign m_rready  = in_data;
   assign m_arlen   = 8'(BURST - 1);
   assign busy      = ~in_idle;
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
         grant_id <= 1'b0;
         m_araddr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_any) begin
                  m_araddr <= pick_wgt ? wgt_araddr : ifm_araddr;
                  grant_id <= pick_wgt;
                  state    <= ADDR;
               end
            end
            ADDR: begin
               if (m_arready) state <= DATA;
            end
            DATA: begin
               if (m_rvalid && m_rlast) begin
                  last_gnt <= grant_id;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RD_ARB_BEAT_CHECK_EN
   localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

   logic [CW-1:0] beat_cnt;
   logic          err_q;

   // Flags an early rlast or a missing rlast on the final beat; routing is unaffected.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
         err_q    <= 1'b0;
      end else if (state == ADDR && m_arready) begin
         beat_cnt <= '0;
      end else if (in_data && m_rvalid) begin
         beat_cnt <= beat_cnt + 1'b1;
         if ((m_rlast && beat_cnt != LAST_BEAT) || (!m_rlast && beat_cnt == LAST_BEAT))
            err_q <= 1'b1;
      end
   end

   assign beat_err = err_q;
`else
   assign beat_err = 1'b0;
`endif

endmodule

// File: doc/rd_port_arbiter.md
# rd_port_arbiter

Round-robin arbiter that shares the single external AXI-style read port between the input-buffer address generator (IFM requester) and the weight-buffer fetcher (WGT requester). It accepts one burst request at a time, forwards it to the memory read-address channel, and steers the returned beats and `rlast` back to the granted requester. It sits between both buffer fetch engines and the top-level memory interface, with one burst outstanding at a time.

## Interface
- `AW`, 32, address width
- `DW`, 64, read data width
- `BURST`, 16, beats per burst; `m_arlen` = `BURST-1`
- `clk` in 1: clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `ifm_arvalid` in 1: IFM burst request
- `ifm_araddr` in AW: IFM burst start address
- `ifm_arready` out 1: IFM request accepted (1-cycle pulse)
- `ifm_rvalid` out 1: beat valid for IFM
- `ifm_rlast` out 1: last beat for IFM
- `wgt_arvalid`, `wgt_araddr`, `wgt_arready`, `wgt_rvalid`, `wgt_rlast`: same as IFM, for the WGT requester
- `rdata` out DW: `m_rdata` passed through, qualified by `*_rvalid`
- `m_arvalid` out 1, `m_araddr` out AW, `m_arlen` out 8: memory read-address channel
- `m_arready` in 1: memory accepts address
- `m_rvalid` in 1, `m_rlast` in 1, `m_rdata` in DW: memory read-data channel
- `m_rready` out 1: arbiter accepts beats
- `grant_id` out 1: 0 = IFM, 1 = WGT; valid while `busy`
- `busy` out 1: burst in progress (state ≠ IDLE)
- `beat_err` out 1: sticky protocol error (see Configuration)

## Operation
- States: IDLE, ADDR, DATA.
- **IDLE:**
  - If only one `*_arvalid` is high, grant that requester.
  - If both are high, grant the requester not named by the round-robin pointer `last_gnt`. `last_gnt` resets to WGT, so IFM wins the first tie.
  - In the same cycle, assert the winner's `*_arready` combinationally.
  - Register its address into `m_araddr` and its ID into `grant_id`, then go to ADDR.
- **ADDR:**
  - `m_arvalid`=1; `m_araddr` and `m_arlen` are held stable.
  - On `m_arvalid & m_arready`, go to DATA. Clear `beat_cnt` to 0.
- **DATA:**
  - `m_rready`=1.
  - Granted requester: `*_rvalid` = `m_rvalid` and `*_rlast` = `m_rvalid & m_rlast`. The other requester's `*_rvalid` and `*_rlast` are 0.
  - `beat_cnt` increments on each `m_rvalid`.
  - On `m_rvalid & m_rlast`: set `last_gnt` = `grant_id` and go to IDLE.
- A requester must hold `*_arvalid` and `*_araddr` until it sees `*_arready`, then drop `*_arvalid` for at least one cycle.
- `m_rvalid` outside DATA is ignored and never forwarded.
- `m_arlen` is the constant `BURST-1`, truncated to 8 bits. `BURST` must be ≤ 256.

## Timing
- Reset values:
  - state IDLE; `last_gnt`=WGT; `beat_cnt`=0; `beat_err`=0
  - `grant_id`=0, `m_araddr`=0
  - `m_arvalid`, `m_rready`, `busy` = 0
  - all `*_arready`, `*_rvalid`, `*_rlast` = 0
- Request to `m_arvalid`: 1 cycle (`arready` in cycle N, `m_arvalid` in N+1).
- `*_rvalid`, `*_rlast`, `rdata`: combinational from the memory channel, 0 cycles.
- The cycle after the `rlast` beat, the arbiter is in IDLE and can grant again. Minimum spacing between successive `m_arvalid` bursts is one cycle beyond `rlast`.
- A request raised during ADDR or DATA waits. It is evaluated in the first IDLE cycle.
- `rst` asserted mid-burst: return to reset values on the next edge. The outstanding burst is abandoned, and any later beats from memory are dropped in IDLE.

## Configuration
- Macro `RD_ARB_BEAT_CHECK_EN`.
- **Defined:**
  - In DATA, `beat_err` is set if `m_rlast` arrives with `beat_cnt` ≠ `BURST-1`.
  - `beat_err` is also set if `beat_cnt` reaches `BURST-1` with `m_rvalid` and `m_rlast`=0.
  - `beat_err` is sticky until `rst`.
  - Routing behaviour is unchanged; the burst still ends only on `m_rlast`.
- **Undefined:**
  - `beat_cnt` logic is not built.
  - `beat_err` is tied 0.

## Test plan
- **Reset:** hold `rst` 3 cycles -> all outputs at the listed reset values; `busy`=0.
- **Single IFM burst:**
  - Stimulus: `ifm_arvalid` with `ifm_araddr`=0x100, `m_arready`=1, 16 beats with `rlast` on beat 16.
  - Required: `ifm_arready` pulse; next cycle `m_araddr`=0x100, `m_arlen`=15; 16 `ifm_rvalid`; `ifm_rlast` once; `wgt_rvalid` never asserted.
- **Simultaneous requests:**
  - Stimulus: IFM (0x200) and WGT (0x800) assert in the same cycle, and keep re-requesting.
  - Required: first grant IFM, then WGT, then IFM; `m_araddr` sequence 0x200, 0x800, 0x200.
- **Backpressure:** `m_arready` held 0 for 5 cycles -> `m_arvalid` and `m_araddr` stable all 5 cycles; DATA entered only after the handshake.
- **Reset mid-burst:** `rst` after beat 7 -> next cycle IDLE; beats 8–16 not forwarded; a fresh WGT request is granted normally.
- **Beat check** (with `RD_ARB_BEAT_CHECK_EN`): `m_rlast` on beat 10 -> `beat_err`=1 from the next cycle and stays set. Without the macro, `beat_err` stays 0.
